// File: rtl/gate_vector_checker.sv
// gate_vector_checker: sweeps every input vector of a gate, settles, and checks dut_y against a truth table
// Ports: clk, rst (async, active-high), start -> sweep begins; dut_y <- gate output; dut_in -> gate inputs;
// busy/done/pass status; err_count mismatches this sweep; fail_valid/fail_vec first failing vector.
module gate_vector_checker #(
  parameter int N_INPUTS = 1,
  parameter int SETTLE_CYCLES = 2,
  parameter logic [(1<<N_INPUTS)-1:0] EXPECTED = 2'b01
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic                dut_y,
  output logic [N_INPUTS-1:0] dut_in,
  output logic                busy,
  output logic                done,
  output logic                pass,
  output logic [N_INPUTS:0]   err_count,
  output logic                fail_valid,
  output logic [N_INPUTS-1:0] fail_vec
);
  localparam int CW = SETTLE_CYCLES > 1 ? $clog2(SETTLE_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(SETTLE_CYCLES - 1);
  typedef enum logic [1:0] {IDLE, SETTLE, CHECK, DONE} state_t;
  state_t state_q, state_d;
  logic [N_INPUTS-1:0] vec_q, vec_d, fvec_q, fvec_d;
  logic [N_INPUTS:0] err_q, err_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic fvalid_q, fvalid_d, mism;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      vec_q    <= '0;
      cnt_q    <= '0;
      err_q    <= '0;
      fvalid_q <= 1'b0;
      fvec_q   <= '0;
    end else begin
      state_q  <= state_d;
      vec_q    <= vec_d;
      cnt_q    <= cnt_d;
      err_q    <= err_d;
      fvalid_q <= fvalid_d;
      fvec_q   <= fvec_d;
    end
  end
  // case inequality so an X/Z from the gate is reported as a mismatch in simulation
  assign mism = dut_y !== EXPECTED[vec_q];
  always_comb begin
    state_d  = state_q;
    vec_d    = vec_q;
    cnt_d    = cnt_q;
    err_d    = err_q;
    fvalid_d = fvalid_q;
    fvec_d   = fvec_q;
    if ((state_q == IDLE || state_q == DONE) && start) begin
      state_d  = SETTLE;
      vec_d    = '0;
      cnt_d    = '0;
      err_d    = '0;
      fvalid_d = 1'b0;
      fvec_d   = '0;
    end else if (state_q == SETTLE) begin
      state_d = cnt_q == CNT_LAST ? CHECK : SETTLE;
      cnt_d   = cnt_q == CNT_LAST ? '0 : cnt_q + 1'b1;
    end else if (state_q == CHECK) begin
      if (mism) begin
        err_d = err_q + 1'b1;
        if (!fvalid_q) begin
          fvalid_d = 1'b1;
          fvec_d   = vec_q;
        end
      end
      state_d = &vec_q ? DONE : SETTLE;
      vec_d   = &vec_q ? vec_q : vec_q + 1'b1;
    end
  end
  assign dut_in     = vec_q;
  assign busy       = state_q == SETTLE || state_q == CHECK;
  assign done       = state_q == DONE;
  assign pass       = done && err_q == '0;
  assign err_count  = err_q;
  assign fail_valid = fvalid_q;
  assign fail_vec   = fvec_q;
endmodule
